// File: rtl/cpu_defs.sv
// Shared definitions for the mycpu_core fetch front end.
//   RESET_PC      : first fetch address after reset
//   SIZE_WORD     : sram-like size code for a 32-bit access
//   fetch_entry_t : one buffered fetch, PC plus returned instruction
package cpu_defs;
    localparam logic [31:0] RESET_PC  = 32'hbfc00000;
    localparam logic [1:0]  SIZE_WORD = 2'b10;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bundle of the fetch unit's bus-side signals:
//   inst_*  : sram-like instruction port toward the AXI bridge
//   fs_*    : valid/ready delivery of {pc, inst} toward decode
//   redir_* : one-cycle redirect strobe and target from branch/exception logic
// Modport master is the fetch unit; slave is its environment.
interface inst_fetch_unit_if;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        fs_valid;
    logic        fs_ready;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        redir_valid;
    logic [31:0] redir_pc;

    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        input  inst_rdata, inst_addr_ok, inst_data_ok,
        output fs_valid, fs_pc, fs_inst,
        input  fs_ready, redir_valid, redir_pc
    );

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        output inst_rdata, inst_addr_ok, inst_data_ok,
        input  fs_valid, fs_pc, fs_inst,
        output fs_ready, redir_valid, redir_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// In-order fetch buffer: DEPTH entries of {pc, inst, done}.
//   alloc_en/alloc_pc : reserve the next slot for an accepted request
//   fill_en/fill_inst : in-order response lands at the fill pointer
//   fill_drop         : response belongs to a redirected fetch; free its slot only
//   deq_en            : decode consumed the head entry
//   flush             : redirect, every buffered instruction becomes undeliverable
//   full              : in-flight plus buffered entries equal DEPTH
//   inflight          : requests accepted but not yet answered
//   head_done/head_entry : head slot toward decode
module fetch_queue
    import cpu_defs::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         alloc_en,
    input  logic [31:0]  alloc_pc,
    input  logic         fill_en,
    input  logic         fill_drop,
    input  logic [31:0]  fill_inst,
    input  logic         deq_en,
    input  logic         flush,
    output logic         full,
    output logic [PW:0]  inflight,
    output logic         head_done,
    output fetch_entry_t head_entry
);
    logic [PW:0] alloc_ptr_reg, fill_ptr_reg, head_ptr_reg;
    logic [PW:0] alloc_ptr_next, fill_ptr_next, head_ptr_next;

    fetch_entry_t     entry_q [DEPTH];
    logic [DEPTH-1:0] done_q;

    assign alloc_ptr_next = alloc_ptr_reg + (PW+1)'(alloc_en);
    assign fill_ptr_next  = fill_ptr_reg + (PW+1)'(fill_en);

    // Dropped responses sit exactly at the head (nothing deliverable precedes
    // them after a flush), so the head walks along with the fill pointer.
    // A flush parks the head at the fill point: everything before it is gone.
    assign head_ptr_next = flush ? fill_ptr_next
                                 : head_ptr_reg + (PW+1)'(deq_en | (fill_en & fill_drop));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alloc_ptr_reg <= '0;
            fill_ptr_reg  <= '0;
            head_ptr_reg  <= '0;
        end else begin
            alloc_ptr_reg <= alloc_ptr_next;
            fill_ptr_reg  <= fill_ptr_next;
            head_ptr_reg  <= head_ptr_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t entry_reg;
            logic         done_reg;
            logic         alloc_hit, fill_hit, head_hit;

            assign alloc_hit = alloc_en && (alloc_ptr_reg[PW-1:0] == PW'(gi));
            assign fill_hit  = fill_en  && (fill_ptr_reg[PW-1:0]  == PW'(gi));
            assign head_hit  = deq_en   && (head_ptr_reg[PW-1:0]  == PW'(gi));

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    entry_reg <= '0;
                    done_reg  <= 1'b0;
                end else begin
                    if (alloc_hit) entry_reg.pc <= alloc_pc;
                    if (fill_hit)  entry_reg.inst <= fill_inst;
                    if (flush)
                        done_reg <= 1'b0;
                    else if (fill_hit && !fill_drop)
                        done_reg <= 1'b1;
                    else if (head_hit)
                        done_reg <= 1'b0;
                end
            end

            assign entry_q[gi] = entry_reg;
            assign done_q[gi]  = done_reg;
        end
    endgenerate

    assign full       = ((alloc_ptr_reg - head_ptr_reg) == (PW+1)'(DEPTH));
    assign inflight   = alloc_ptr_reg - fill_ptr_reg;
    assign head_done  = done_q[head_ptr_reg[PW-1:0]];
    assign head_entry = entry_q[head_ptr_reg[PW-1:0]];
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: PC generation, sram-like word reads, in-order
// buffering of {pc, inst}, and redirect handling with in-flight discard.
//   clk, resetn : clock and asynchronous active-low reset
//   bus         : sram-like port, decode handshake and redirect strobe
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
    parameter int          DEPTH    = 4,
    localparam int         PW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    inst_fetch_unit_if.master bus
);
    logic [31:0] pc_reg, pc_next;
    logic        active_reg;
    logic        pend_reg, pend_next;         // redirect waiting behind a held request
    logic [31:0] pend_pc_reg, pend_pc_next;
    logic [PW:0] discard_reg, discard_next;

    logic                 full, head_done;
    logic [PW:0]          inflight;
    cpu_defs::fetch_entry_t head_entry;
    logic                 inst_req, accept, fill_en, fill_drop, deq_en, held;

    // active_reg keeps the request low through the reset cycle itself.
    assign inst_req  = active_reg & ~full;
    assign accept    = inst_req & bus.inst_addr_ok;
    assign fill_en   = bus.inst_data_ok & (inflight != '0);   // unsolicited data ignored
    assign fill_drop = (discard_reg != '0);
    assign deq_en    = head_done & bus.fs_ready;
    // A pending request must keep its address, so the redirect is deferred.
    assign held      = bus.redir_valid & inst_req & ~bus.inst_addr_ok;

    always_comb begin
        pc_next      = pc_reg;
        pend_next    = pend_reg;
        pend_pc_next = pend_pc_reg;
        discard_next = discard_reg;
        if (bus.redir_valid) begin
            // Everything still outstanding after this edge is stale.
            discard_next = inflight + (PW+1)'(accept) - (PW+1)'(fill_en);
            if (held) begin
                pend_next    = 1'b1;
                pend_pc_next = bus.redir_pc;
            end else begin
                pend_next = 1'b0;
                pc_next   = bus.redir_pc;
            end
        end else begin
            discard_next = discard_reg + (PW+1)'(accept & pend_reg)
                                       - (PW+1)'(fill_en & fill_drop);
            if (accept) begin
                pc_next   = pend_reg ? pend_pc_reg : pc_reg + 32'd4;
                pend_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_reg      <= RESET_PC;
            active_reg  <= 1'b0;
            pend_reg    <= 1'b0;
            pend_pc_reg <= '0;
            discard_reg <= '0;
        end else begin
            pc_reg      <= pc_next;
            active_reg  <= 1'b1;
            pend_reg    <= pend_next;
            pend_pc_reg <= pend_pc_next;
            discard_reg <= discard_next;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .resetn     (resetn),
        .alloc_en   (accept),
        .alloc_pc   (pc_reg),
        .fill_en    (fill_en),
        .fill_drop  (fill_drop),
        .fill_inst  (bus.inst_rdata),
        .deq_en     (deq_en),
        .flush      (bus.redir_valid),
        .full       (full),
        .inflight   (inflight),
        .head_done  (head_done),
        .head_entry (head_entry)
    );

    assign bus.inst_req   = inst_req;
    assign bus.inst_wr    = 1'b0;
    assign bus.inst_size  = cpu_defs::SIZE_WORD;
    assign bus.inst_addr  = pc_reg & 32'hffff_fffc;
    assign bus.inst_wdata = 32'h0;
    assign bus.fs_valid   = head_done;
    assign bus.fs_pc      = head_entry.pc;
    assign bus.fs_inst    = head_entry.inst;
endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    inst_fetch_unit_if bus();

    inst_fetch_unit #(.RESET_PC(32'hbfc00000), .DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int acc_cnt = 0;
    bit addr_en = 1'b0;
    bit data_en = 1'b0;
    logic [31:0] q[$];   // addresses accepted by the bridge, answered in order

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hdeadbeef;
    endfunction

    task automatic drive();
        bus.inst_addr_ok = addr_en;
        bus.inst_data_ok = data_en && (q.size() != 0);
        bus.inst_rdata   = (q.size() != 0) ? memf(q[0]) : 32'h0;
    endtask

    // Advance one clock; bridge model records what the DUT saw at the edge.
    task automatic step();
        bit acc, dok;
        logic [31:0] a;
        drive();
        @(negedge clk);
        acc = bus.inst_req && bus.inst_addr_ok;
        dok = bus.inst_data_ok;
        a   = bus.inst_addr;
        @(posedge clk);
        #1;
        if (dok) void'(q.pop_front());
        if (acc) begin
            q.push_back(a);
            acc_cnt++;
        end
        drive();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        addr_en = 1'b0;
        data_en = 1'b0;
        bus.fs_ready = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc = 32'h0;
        q.delete();
        drive();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step();
        acc_cnt = 0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.fs_ready = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc = 32'h0;
        q.delete();
        drive();
        @(posedge clk);
        #1;
        n_vec++; if (bus.inst_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", bus.inst_req); end
        n_vec++; if (bus.fs_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bus.fs_valid); end
        n_vec++; if (bus.fs_pc !== 32'h0) begin n_err++; $display("FAIL reset_fs_pc: got %h expected 00000000", bus.fs_pc); end
        n_vec++; if (bus.fs_inst !== 32'h0) begin n_err++; $display("FAIL reset_fs_inst: got %h expected 00000000", bus.fs_inst); end
        n_vec++; if (bus.inst_addr !== 32'hbfc00000) begin n_err++; $display("FAIL reset_addr: got %h expected bfc00000", bus.inst_addr); end
        n_vec++; if (bus.inst_size !== 2'b10 || bus.inst_wr !== 1'b0 || bus.inst_wdata !== 32'h0) begin
            n_err++; $display("FAIL tie_offs: got size %b wr %b wdata %h expected 10 0 00000000", bus.inst_size, bus.inst_wr, bus.inst_wdata);
        end
        resetn = 1'b1;
        n_vec++; if (bus.inst_req !== 1'b0) begin n_err++; $display("FAIL req_before_edge: got %b expected 0", bus.inst_req); end
        step();
        n_vec++; if (bus.inst_req !== 1'b1) begin n_err++; $display("FAIL req_after_reset: got %b expected 1", bus.inst_req); end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        addr_en = 1'b1; data_en = 1'b1; bus.fs_ready = 1'b1;
        step();
        n_vec++; if (bus.fs_valid !== 1'b0) begin n_err++; $display("FAIL stream_latency: got %b expected 0", bus.fs_valid); end
        step();
        for (int i = 0; i < 5; i++) begin
            exp_pc = 32'hbfc00000 + 32'(4 * i);
            n_vec++; if (bus.fs_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, bus.fs_valid); end
            n_vec++; if (bus.fs_pc !== exp_pc) begin n_err++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, bus.fs_pc, exp_pc); end
            n_vec++; if (bus.fs_inst !== memf(exp_pc)) begin n_err++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, bus.fs_inst, memf(exp_pc)); end
            n_vec++; if (bus.inst_req !== 1'b1) begin n_err++; $display("FAIL stream_req[%0d]: got %b expected 1", i, bus.inst_req); end
            step();
        end
        $display("test_stream done");
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        do_reset();
        addr_en = 1'b1; data_en = 1'b1; bus.fs_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        n_vec++; if (acc_cnt !== 4) begin n_err++; $display("FAIL full_accepts: got %0d expected 4", acc_cnt); end
        n_vec++; if (bus.inst_req !== 1'b0) begin n_err++; $display("FAIL full_req: got %b expected 0", bus.inst_req); end
        bus.fs_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_pc = 32'hbfc00000 + 32'(4 * i);
            n_vec++; if (bus.fs_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, bus.fs_valid); end
            n_vec++; if (bus.fs_pc !== exp_pc) begin n_err++; $display("FAIL drain_pc[%0d]: got %h expected %h", i, bus.fs_pc, exp_pc); end
            step();
        end
        $display("test_backpressure done");
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        addr_en = 1'b1; data_en = 1'b0; bus.fs_ready = 1'b1;
        step();
        step();
        bus.redir_valid = 1'b1; bus.redir_pc = 32'h80001000;
        step();
        bus.redir_valid = 1'b0;
        n_vec++; if (bus.inst_addr !== 32'h80001000) begin n_err++; $display("FAIL redir_addr: got %h expected 80001000", bus.inst_addr); end
        n_vec++; if (acc_cnt !== 3) begin n_err++; $display("FAIL redir_inflight: got %0d expected 3", acc_cnt); end
        data_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (bus.fs_valid !== 1'b0) begin n_err++; $display("FAIL redir_drop[%0d]: got fs_valid %b pc %h expected 0", i, bus.fs_valid, bus.fs_pc); end
            step();
        end
        n_vec++; if (bus.fs_valid !== 1'b1 || bus.fs_pc !== 32'h80001000) begin
            n_err++; $display("FAIL redir_target: got valid %b pc %h expected 1 80001000", bus.fs_valid, bus.fs_pc);
        end
        n_vec++; if (bus.fs_inst !== memf(32'h80001000)) begin n_err++; $display("FAIL redir_inst: got %h expected %h", bus.fs_inst, memf(32'h80001000)); end
        $display("test_redirect_inflight done");
    endtask

    task automatic test_redirect_held();
        do_reset();
        addr_en = 1'b0; data_en = 1'b1; bus.fs_ready = 1'b1;
        bus.redir_valid = 1'b1; bus.redir_pc = 32'h80002000;
        step();
        bus.redir_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_vec++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc00000) begin
                n_err++; $display("FAIL held_addr[%0d]: got req %b addr %h expected 1 bfc00000", i, bus.inst_req, bus.inst_addr);
            end
            step();
        end
        addr_en = 1'b1;
        step();
        n_vec++; if (bus.inst_addr !== 32'h80002000) begin n_err++; $display("FAIL held_switch: got %h expected 80002000", bus.inst_addr); end
        step();
        n_vec++; if (bus.fs_valid !== 1'b0) begin n_err++; $display("FAIL held_drop: got fs_valid %b pc %h expected 0", bus.fs_valid, bus.fs_pc); end
        step();
        n_vec++; if (bus.fs_valid !== 1'b1 || bus.fs_pc !== 32'h80002000) begin
            n_err++; $display("FAIL held_target: got valid %b pc %h expected 1 80002000", bus.fs_valid, bus.fs_pc);
        end
        $display("test_redirect_held done");
    endtask

    task automatic test_same_cycle();
        do_reset();
        addr_en = 1'b1; data_en = 1'b0; bus.fs_ready = 1'b1;
        step();
        step();
        data_en = 1'b1;
        bus.redir_valid = 1'b1; bus.redir_pc = 32'h80003000;
        step();
        bus.redir_valid = 1'b0;
        n_vec++; if (bus.inst_addr !== 32'h80003000) begin n_err++; $display("FAIL same_addr: got %h expected 80003000", bus.inst_addr); end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (bus.fs_valid !== 1'b0) begin n_err++; $display("FAIL same_stale[%0d]: got fs_valid %b pc %h expected 0", i, bus.fs_valid, bus.fs_pc); end
            step();
        end
        n_vec++; if (bus.fs_valid !== 1'b1 || bus.fs_pc !== 32'h80003000) begin
            n_err++; $display("FAIL same_target: got valid %b pc %h expected 1 80003000", bus.fs_valid, bus.fs_pc);
        end
        step();
        n_vec++; if (bus.fs_valid !== 1'b1 || bus.fs_pc !== 32'h80003004) begin
            n_err++; $display("FAIL same_next: got valid %b pc %h expected 1 80003004", bus.fs_valid, bus.fs_pc);
        end
        $display("test_same_cycle done");
    endtask

    task automatic test_midrun_reset();
        do_reset();
        addr_en = 1'b1; data_en = 1'b1; bus.fs_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        n_vec++; if (bus.inst_req !== 1'b0 || bus.fs_valid !== 1'b1) begin
            n_err++; $display("FAIL pre_reset_full: got req %b valid %b expected 0 1", bus.inst_req, bus.fs_valid);
        end
        resetn = 1'b0;
        #1;
        n_vec++; if (bus.inst_req !== 1'b0 || bus.fs_valid !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got req %b valid %b expected 0 0", bus.inst_req, bus.fs_valid);
        end
        n_vec++; if (bus.fs_pc !== 32'h0 || bus.inst_addr !== 32'hbfc00000) begin
            n_err++; $display("FAIL async_reset_regs: got fs_pc %h addr %h expected 00000000 bfc00000", bus.fs_pc, bus.inst_addr);
        end
        q.delete();
        addr_en = 1'b0;
        drive();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step();
        n_vec++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc00000) begin
            n_err++; $display("FAIL restart: got req %b addr %h expected 1 bfc00000", bus.inst_req, bus.inst_addr);
        end
        $display("test_midrun_reset done");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_held();
        test_same_cycle();
        test_midrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
